// File: rtl/stage_id_q_pkg.sv
// Shared opcodes, operand-source encodings and micro-op field widths for the
// RV32I decode stage.
package stage_id_q_pkg;

  localparam logic [6:0] OPCODE_ALUR   = 7'b0110011;
  localparam logic [6:0] OPCODE_ALUI   = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;

  localparam int unsigned ALU_SRC_W     = 2;
  localparam int unsigned ALU_OP_W      = 4;
  localparam int unsigned BRANCH_TYPE_W = 3;
  localparam int unsigned MEM_SIZE_W    = 3;

  // arg1: R/PC/ZERO, arg2: R/IMM/FOUR share the same code points
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_R    = 2'd0;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_PC   = 2'd1;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM  = 2'd1;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_ZERO = 2'd2;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_FOUR = 2'd2;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'b0000;

endpackage

// File: rtl/stage_id_q_id_decoder.sv
// Purely combinational RV32I base decoder: instruction word to micro-op fields.
module stage_id_q_id_decoder
  import stage_id_q_pkg::*;
#(
  parameter int unsigned INST_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [INST_W-1:0]        inst,
  output logic                     reg_wr,
  output logic [REG_ADDR_W-1:0]    reg_addr_rd,
  output logic [REG_ADDR_W-1:0]    reg_addr_r1,
  output logic [REG_ADDR_W-1:0]    reg_addr_r2,
  output logic [ALU_OP_W-1:0]      alu_op,
  output logic [ALU_SRC_W-1:0]     alu_src_arg1,
  output logic [ALU_SRC_W-1:0]     alu_src_arg2,
  output logic [DATA_W-1:0]        imm,
  output logic                     is_branch,
  output logic [BRANCH_TYPE_W-1:0] branch_type,
  output logic                     is_jump,
  output logic                     jump_reg,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [MEM_SIZE_W-1:0]    mem_size,
  output logic                     illegal
);

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        writes_rd;

  assign opcode = inst[6:0];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    writes_rd    = 1'b0;
    illegal      = 1'b0;
    alu_op       = ALU_OP_ADD;
    alu_src_arg1 = ALU_SRC_R;
    alu_src_arg2 = ALU_SRC_R;
    imm32        = '0;
    is_branch    = 1'b0;
    is_jump      = 1'b0;
    jump_reg     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    case (opcode)
      OPCODE_ALUR: begin
        if (func7 == 7'b0000000 || func7 == 7'b0100000) begin
          alu_op    = {func7[5], func3};
          writes_rd = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPCODE_ALUI: begin
        // Shift-immediates reuse func7; only SRAI may set bit 5
        if ((func3 == 3'b001 && func7 != 7'b0000000) ||
            (func3 == 3'b101 && func7 != 7'b0000000 && func7 != 7'b0100000)) begin
          illegal = 1'b1;
        end else begin
          alu_op       = {(func3 == 3'b101) & func7[5], func3};
          alu_src_arg2 = ALU_SRC_IMM;
          imm32        = imm_i;
          writes_rd    = 1'b1;
        end
      end
      OPCODE_LUI: begin
        alu_src_arg1 = ALU_SRC_ZERO;
        alu_src_arg2 = ALU_SRC_IMM;
        imm32        = imm_u;
        writes_rd    = 1'b1;
      end
      OPCODE_AUIPC: begin
        alu_src_arg1 = ALU_SRC_PC;
        alu_src_arg2 = ALU_SRC_IMM;
        imm32        = imm_u;
        writes_rd    = 1'b1;
      end
      OPCODE_JAL, OPCODE_JALR: begin
        alu_src_arg1 = ALU_SRC_PC;
        alu_src_arg2 = ALU_SRC_FOUR;
        is_jump      = 1'b1;
        jump_reg     = (opcode == OPCODE_JALR);
        imm32        = (opcode == OPCODE_JALR) ? imm_i : imm_j;
        writes_rd    = 1'b1;
      end
      OPCODE_BRANCH: begin
        alu_src_arg1 = ALU_SRC_PC;
        alu_src_arg2 = ALU_SRC_IMM;
        is_branch    = 1'b1;
        imm32        = imm_b;
      end
      OPCODE_LOAD: begin
        alu_src_arg2 = ALU_SRC_IMM;
        mem_rd       = 1'b1;
        imm32        = imm_i;
        writes_rd    = 1'b1;
      end
      OPCODE_STORE: begin
        alu_src_arg2 = ALU_SRC_IMM;
        mem_wr       = 1'b1;
        imm32        = imm_s;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign reg_addr_rd = REG_ADDR_W'(inst[11:7]);
  assign reg_addr_r1 = REG_ADDR_W'(inst[19:15]);
  assign reg_addr_r2 = REG_ADDR_W'(inst[24:20]);
  assign reg_wr      = writes_rd && (inst[11:7] != 5'd0) && !illegal;
  assign imm         = DATA_W'($signed(imm32));
  assign branch_type = func3;
  assign mem_size    = func3;

endmodule

// File: rtl/stage_id_q.sv
// Decode stage with valid/ready handshakes and a DEPTH-entry decoded micro-op
// FIFO; outputs are driven straight from the head entry.
module stage_id_q
  import stage_id_q_pkg::*;
#(
  parameter int unsigned INST_W      = 32,
  parameter int unsigned INST_ADDR_W = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_W-1:0]        inst,
  input  logic [INST_ADDR_W-1:0]   pc,
  output logic [REG_ADDR_W-1:0]    regfile_addr1,
  output logic [REG_ADDR_W-1:0]    regfile_addr2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_reg_wr,
  output logic [REG_ADDR_W-1:0]    out_reg_addr_rd,
  output logic [REG_ADDR_W-1:0]    out_reg_addr_r1,
  output logic [REG_ADDR_W-1:0]    out_reg_addr_r2,
  output logic [ALU_OP_W-1:0]      out_alu_op,
  output logic [ALU_SRC_W-1:0]     out_alu_src_arg1,
  output logic [ALU_SRC_W-1:0]     out_alu_src_arg2,
  output logic [DATA_W-1:0]        out_imm,
  output logic                     out_is_branch,
  output logic [BRANCH_TYPE_W-1:0] out_branch_type,
  output logic                     out_is_jump,
  output logic                     out_jump_reg,
  output logic                     out_mem_rd,
  output logic                     out_mem_wr,
  output logic [MEM_SIZE_W-1:0]    out_mem_size,
  output logic                     out_illegal,
  output logic [INST_ADDR_W-1:0]   out_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                     reg_wr;
    logic [REG_ADDR_W-1:0]    reg_addr_rd;
    logic [REG_ADDR_W-1:0]    reg_addr_r1;
    logic [REG_ADDR_W-1:0]    reg_addr_r2;
    logic [ALU_OP_W-1:0]      alu_op;
    logic [ALU_SRC_W-1:0]     alu_src_arg1;
    logic [ALU_SRC_W-1:0]     alu_src_arg2;
    logic [DATA_W-1:0]        imm;
    logic                     is_branch;
    logic [BRANCH_TYPE_W-1:0] branch_type;
    logic                     is_jump;
    logic                     jump_reg;
    logic                     mem_rd;
    logic                     mem_wr;
    logic [MEM_SIZE_W-1:0]    mem_size;
    logic                     illegal;
    logic [INST_ADDR_W-1:0]   pc;
  } uop_t;

  uop_t            dec_uop, head;
  uop_t            mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  stage_id_q_id_decoder #(
    .INST_W     (INST_W),
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_id_decoder (
    .inst         (inst),
    .reg_wr       (dec_uop.reg_wr),
    .reg_addr_rd  (dec_uop.reg_addr_rd),
    .reg_addr_r1  (dec_uop.reg_addr_r1),
    .reg_addr_r2  (dec_uop.reg_addr_r2),
    .alu_op       (dec_uop.alu_op),
    .alu_src_arg1 (dec_uop.alu_src_arg1),
    .alu_src_arg2 (dec_uop.alu_src_arg2),
    .imm          (dec_uop.imm),
    .is_branch    (dec_uop.is_branch),
    .branch_type  (dec_uop.branch_type),
    .is_jump      (dec_uop.is_jump),
    .jump_reg     (dec_uop.jump_reg),
    .mem_rd       (dec_uop.mem_rd),
    .mem_wr       (dec_uop.mem_wr),
    .mem_size     (dec_uop.mem_size),
    .illegal      (dec_uop.illegal)
  );
  assign dec_uop.pc = pc;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready  = (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= dec_uop;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign regfile_addr1    = REG_ADDR_W'(inst[19:15]);
  assign regfile_addr2    = REG_ADDR_W'(inst[24:20]);
  assign out_reg_wr       = head.reg_wr;
  assign out_reg_addr_rd  = head.reg_addr_rd;
  assign out_reg_addr_r1  = head.reg_addr_r1;
  assign out_reg_addr_r2  = head.reg_addr_r2;
  assign out_alu_op       = head.alu_op;
  assign out_alu_src_arg1 = head.alu_src_arg1;
  assign out_alu_src_arg2 = head.alu_src_arg2;
  assign out_imm          = head.imm;
  assign out_is_branch    = head.is_branch;
  assign out_branch_type  = head.branch_type;
  assign out_is_jump      = head.is_jump;
  assign out_jump_reg     = head.jump_reg;
  assign out_mem_rd       = head.mem_rd;
  assign out_mem_wr       = head.mem_wr;
  assign out_mem_size     = head.mem_size;
  assign out_illegal      = head.illegal;
  assign out_pc           = head.pc;

endmodule

// File: tb/tb_stage_id_q.sv
// Randomized and directed bench for stage_id_q against an in-bench queue model
// and a decode model built from the RV32I encoding rules.
module tb_stage_id_q;

  localparam int unsigned DEPTH = 2;
  localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f,
                                     7'h67, 7'h63, 7'h03, 7'h23};

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0, pc = '0;
  logic        in_ready, out_valid;
  logic [4:0]  regfile_addr1, regfile_addr2;
  logic        out_reg_wr, out_is_branch, out_is_jump, out_jump_reg;
  logic        out_mem_rd, out_mem_wr, out_illegal;
  logic [4:0]  out_reg_addr_rd, out_reg_addr_r1, out_reg_addr_r2;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_alu_src_arg1, out_alu_src_arg2;
  logic [31:0] out_imm, out_pc;
  logic [2:0]  out_branch_type, out_mem_size;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        reg_wr;
    logic [4:0]  rd, r1, r2;
    logic [3:0]  alu_op;
    logic [1:0]  src1, src2;
    logic [31:0] imm;
    logic        is_branch;
    logic [2:0]  branch_type;
    logic        is_jump, jump_reg, mem_rd, mem_wr;
    logic [2:0]  mem_size;
    logic        illegal;
    logic [31:0] pc;
  } op_t;

  op_t obs;
  op_t mq[$];

  assign obs = {out_reg_wr, out_reg_addr_rd, out_reg_addr_r1, out_reg_addr_r2, out_alu_op,
                out_alu_src_arg1, out_alu_src_arg2, out_imm, out_is_branch, out_branch_type,
                out_is_jump, out_jump_reg, out_mem_rd, out_mem_wr, out_mem_size, out_illegal,
                out_pc};

  always #5 clk = ~clk;

  stage_id_q #(
    .INST_W      (32),
    .INST_ADDR_W (32),
    .DATA_W      (32),
    .REG_ADDR_W  (5),
    .DEPTH       (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .inst             (inst),
    .pc               (pc),
    .regfile_addr1    (regfile_addr1),
    .regfile_addr2    (regfile_addr2),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_reg_wr       (out_reg_wr),
    .out_reg_addr_rd  (out_reg_addr_rd),
    .out_reg_addr_r1  (out_reg_addr_r1),
    .out_reg_addr_r2  (out_reg_addr_r2),
    .out_alu_op       (out_alu_op),
    .out_alu_src_arg1 (out_alu_src_arg1),
    .out_alu_src_arg2 (out_alu_src_arg2),
    .out_imm          (out_imm),
    .out_is_branch    (out_is_branch),
    .out_branch_type  (out_branch_type),
    .out_is_jump      (out_is_jump),
    .out_jump_reg     (out_jump_reg),
    .out_mem_rd       (out_mem_rd),
    .out_mem_wr       (out_mem_wr),
    .out_mem_size     (out_mem_size),
    .out_illegal      (out_illegal),
    .out_pc           (out_pc)
  );

  // Reference decode: srcs arg1 0=R 1=PC 2=ZERO, arg2 0=R 1=IMM 2=FOUR
  function automatic op_t ref_decode(input logic [31:0] w, input logic [31:0] p);
    op_t e = '0;
    bit  wr = 0;
    int  i_imm = $signed(w[31:20]);
    int  s_imm = $signed({w[31:25], w[11:7]});
    int  b_imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
    int  j_imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
    int  u_imm = {w[31:12], 12'h000};
    logic [6:0] f7 = w[31:25];
    logic [2:0] f3 = w[14:12];
    e.rd = w[11:7];
    e.r1 = w[19:15];
    e.r2 = w[24:20];
    e.pc = p;
    case (w[6:0])
      7'h33: if (f7 == 7'h00 || f7 == 7'h20) begin
        e.alu_op = {f7[5], f3}; wr = 1;
      end else e.illegal = 1;
      7'h13: if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20)) e.illegal = 1;
      else begin
        e.alu_op = {(f3 == 5) ? f7[5] : 1'b0, f3}; e.src2 = 1; e.imm = i_imm; wr = 1;
      end
      7'h37: begin e.src1 = 2; e.src2 = 1; e.imm = u_imm; wr = 1; end
      7'h17: begin e.src1 = 1; e.src2 = 1; e.imm = u_imm; wr = 1; end
      7'h6f: begin e.src1 = 1; e.src2 = 2; e.is_jump = 1; e.imm = j_imm; wr = 1; end
      7'h67: begin
        e.src1 = 1; e.src2 = 2; e.is_jump = 1; e.jump_reg = 1; e.imm = i_imm; wr = 1;
      end
      7'h63: begin
        e.src1 = 1; e.src2 = 1; e.is_branch = 1; e.branch_type = f3; e.imm = b_imm;
      end
      7'h03: begin e.src2 = 1; e.mem_rd = 1; e.mem_size = f3; e.imm = i_imm; wr = 1; end
      7'h23: begin e.src2 = 1; e.mem_wr = 1; e.mem_size = f3; e.imm = s_imm; end
      default: e.illegal = 1;
    endcase
    e.reg_wr = wr && (e.rd != 0) && !e.illegal;
    return e;
  endfunction

  // Clear fields that carry no meaning for the given op kind
  function automatic op_t relevant(input op_t o);
    op_t m = o;
    if (o.illegal) begin
      m.alu_op = '0; m.src1 = '0; m.src2 = '0; m.imm = '0; m.jump_reg = 1'b0;
    end
    if (!o.is_branch) m.branch_type = '0;
    if (!(o.mem_rd || o.mem_wr)) m.mem_size = '0;
    return m;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    if (k < 8) w[6:0] = OPS[$urandom_range(0, 8)];
    if (k < 5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // Advance one clock, updating the queue model with the handshake rules
  task automatic tick();
    bit  do_push = in_valid && (mq.size() < DEPTH) && !flush;
    bit  do_pop  = (mq.size() != 0) && out_ready && !flush;
    op_t nw      = ref_decode(inst, pc);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(nw);
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_head_fields: got %h expected 0", obs);
    end
  endtask

  task automatic test_decode();
    logic [31:0] vec [11] = '{32'h00500093, 32'h402081B3, 32'h00000013, 32'hFE000CE3,
                              32'h00812283, 32'h010000EF, 32'hABCDE3B7, 32'h00001117,
                              32'h00512623, 32'hFFFFFFFF, 32'h02208133};
    op_t seen [11];
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      inst     = vec[i];
      pc       = (i == 3) ? 32'h100 : 32'h1000 + 32'(i * 4);
      tick();
      seen[i] = obs;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL decode_valid[%0d]: got %b expected 1", i, out_valid);
      end
      checks++;
      if (relevant(obs) !== relevant(mq[0])) begin
        errors++;
        $display("FAIL decode_model[%0d]: got %h expected %h", i, relevant(obs),
                 relevant(mq[0]));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL decode_drain: got out_valid=%b expected 0", out_valid);
    end
    checks++;
    if ({seen[0].reg_wr, seen[0].rd, seen[0].alu_op, seen[0].src1, seen[0].src2, seen[0].imm}
        !== {1'b1, 5'd1, 4'b0000, 2'd0, 2'd1, 32'd5}) begin
      errors++; $display("FAIL addi: got %h", seen[0]);
    end
    checks++;
    if ({seen[1].alu_op, seen[1].src1, seen[1].src2, seen[1].r1, seen[1].r2, seen[1].rd}
        !== {4'b1000, 2'd0, 2'd0, 5'd1, 5'd2, 5'd3}) begin
      errors++; $display("FAIL sub: got %h", seen[1]);
    end
    checks++;
    if (seen[2].reg_wr !== 1'b0) begin
      errors++; $display("FAIL addi_x0_reg_wr: got %b expected 0", seen[2].reg_wr);
    end
    checks++;
    if ({seen[3].is_branch, seen[3].branch_type, seen[3].imm, seen[3].src1, seen[3].src2,
         seen[3].pc, seen[3].reg_wr} !== {1'b1, 3'b000, 32'hFFFFFFF8, 2'd1, 2'd1, 32'h100, 1'b0})
    begin
      errors++; $display("FAIL beq: got %h", seen[3]);
    end
    checks++;
    if ({seen[4].mem_rd, seen[4].mem_size, seen[4].imm} !== {1'b1, 3'b010, 32'd8}) begin
      errors++; $display("FAIL lw: got %h", seen[4]);
    end
    checks++;
    if ({seen[5].is_jump, seen[5].src1, seen[5].src2, seen[5].imm, seen[5].reg_wr}
        !== {1'b1, 2'd1, 2'd2, 32'd16, 1'b1}) begin
      errors++; $display("FAIL jal: got %h", seen[5]);
    end
    checks++;
    if ({seen[9].illegal, seen[9].reg_wr, seen[9].mem_rd, seen[9].mem_wr, seen[9].is_branch,
         seen[9].is_jump} !== 6'b100000) begin
      errors++; $display("FAIL illegal_flags: got %h", seen[9]);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst = 32'h00500093; pc = 32'h200; tick();
    inst = 32'h402081B3; pc = 32'h204; tick();
    inst = 32'h00812283; pc = 32'h208;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: got in_ready=%b expected 0", in_ready);
    end
    tick();
    checks++;
    if (relevant(obs) !== relevant(mq[0]) || obs.pc !== 32'h200) begin
      errors++; $display("FAIL bp_head_hold: got %h expected %h", obs, mq[0]);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || obs.alu_op !== 4'b1000 || obs.pc !== 32'h204) begin
      errors++;
      $display("FAIL bp_second: got in_ready=%b alu_op=%b pc=%h expected 1 1000 204",
               in_ready, obs.alu_op, obs.pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || obs.mem_rd !== 1'b1 || obs.pc !== 32'h208) begin
      errors++; $display("FAIL bp_third: got valid=%b mem_rd=%b pc=%h expected 1 1 208",
                         out_valid, obs.mem_rd, obs.pc);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst = 32'h00500093; tick();
    inst = 32'h402081B3; tick();
    flush = 1'b1;
    inst  = 32'h010000EF;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full: got valid=%b ready=%b expected 0 1",
                         out_valid, in_ready);
    end
    flush = 1'b0;
    tick();
    flush = 1'b1;
    inst  = 32'h00812283;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got out_valid=%b expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_after: got valid=%b ready=%b expected 0 1",
                         out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst = 32'h00500093; pc = 32'h300;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    mq.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      errors++; $display("FAIL reset_mid: got valid=%b ready=%b head=%h expected 0 1 0",
                         out_valid, in_ready, obs);
    end
    #1 rst = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || relevant(obs) !== relevant(mq[0])) begin
      errors++; $display("FAIL reset_recover: got valid=%b head=%h expected 1 %h",
                         out_valid, obs, mq[0]);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      inst      = rand_inst();
      pc        = $urandom & 32'hFFFF_FFFC;
      checks++;
      if (in_ready !== (mq.size() < DEPTH) || out_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rand_hs[%0d]: got ready=%b valid=%b model size %0d",
                           c, in_ready, out_valid, mq.size());
      end
      checks++;
      if (regfile_addr1 !== inst[19:15] || regfile_addr2 !== inst[24:20]) begin
        errors++; $display("FAIL rand_rf[%0d]: got %0d %0d expected %0d %0d", c,
                           regfile_addr1, regfile_addr2, inst[19:15], inst[24:20]);
      end
      if (mq.size() != 0) begin
        checks++;
        if (relevant(obs) !== relevant(mq[0])) begin
          errors++; $display("FAIL rand_head[%0d]: got %h expected %h", c, relevant(obs),
                             relevant(mq[0]));
        end
      end
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    test_decode();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/stage_id_q.md
Name: stage_id_q

Overview:
- Parametrised decode stage for the in-order RV32I core pipeline; sits between STAGE_FE and the execute stage.
- Replaces the single-register decode stage with valid/ready handshakes on both sides.
- Adds a DEPTH-entry decoded micro-op queue and full RV32I base decode: ALU-R, ALU-I, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE.
- Flags illegal encodings.

Parameters:
- INST_W, 32, instruction width
- INST_ADDR_W, 32, PC width
- DATA_W, 32, immediate/data width (at least 32)
- REG_ADDR_W, 5, register index width
- DEPTH, 2, decoded-op queue entries (at least 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; kills the queue and the input
- in_valid  in  1  FE presents an instruction
- in_ready  out  1  stage accepts an instruction
- inst  in  INST_W  instruction word
- pc  in  INST_ADDR_W  PC of inst
- regfile_addr1  out  REG_ADDR_W  inst[19:15], combinational
- regfile_addr2  out  REG_ADDR_W  inst[24:20], combinational
- out_valid  out  1  head micro-op valid
- out_ready  in  1  execute consumes head
- out_reg_wr  out  1  writes rd
- out_reg_addr_rd  out  REG_ADDR_W  rd field
- out_reg_addr_r1  out  REG_ADDR_W  rs1 field
- out_reg_addr_r2  out  REG_ADDR_W  rs2 field
- out_alu_op  out  4  {rev, func3}
- out_alu_src_arg1  out  2  0=R, 1=PC, 2=ZERO
- out_alu_src_arg2  out  2  0=R, 1=IMM, 2=FOUR
- out_imm  out  DATA_W  sign-extended immediate
- out_is_branch  out  1  conditional branch
- out_branch_type  out  3  func3
- out_is_jump  out  1  JAL/JALR
- out_jump_reg  out  1  JALR (target = rs1 + imm)
- out_mem_rd  out  1  load
- out_mem_wr  out  1  store
- out_mem_size  out  3  func3 of load/store
- out_illegal  out  1  unsupported encoding
- out_pc  out  INST_ADDR_W  PC of head op

Behaviour:
- Reset (async, rst=1):
  - Queue empty, out_valid=0, in_ready=1.
  - All head fields 0 (outputs are driven from the head entry).
- Handshakes:
  - Push when in_valid && in_ready && !flush.
  - Pop when out_valid && out_ready && !flush.
  - in_ready = (count < DEPTH); no combinational path from out_ready to in_ready.
  - Full queue: no push even if a pop happens the same cycle.
- Latency: an op accepted at edge N is visible with out_valid=1 after edge N (one cycle) when the queue was empty.
- Ordering and occupancy:
  - Strict FIFO order.
  - Push and pop in the same cycle leave count unchanged.
  - Circular read/write pointers wrap at DEPTH (non-power-of-2 supported).
- Flush:
  - Synchronous; highest priority.
  - count, rd_ptr and wr_ptr reset to 0; that cycle's input is dropped; out_valid=0 next cycle.
  - Head fields are don't-care while out_valid=0.
- Decode (combinational, captured on push):
  - ALUR (func7 0000000/0100000): alu_op={func7[5], func3}, src R/R, reg_wr.
  - ALUI: alu_op[3]=func7[5] only when func3=101, else 0. imm=sext(I). src R/IMM.
  - LUI: src ZERO/IMM, imm={U, 12'b0}, ADD.
  - AUIPC: src PC/IMM, imm={U, 12'b0}, ADD.
  - JAL: src PC/FOUR, ADD, is_jump, imm=sext({J, 0}).
  - JALR: src PC/FOUR, ADD, is_jump, jump_reg, imm=sext(I).
  - BRANCH: src PC/IMM, ADD, is_branch, imm=sext({B, 0}), reg_wr=0.
  - LOAD: src R/IMM, ADD, mem_rd, imm=sext(I), reg_wr.
  - STORE: src R/IMM, ADD, mem_wr, imm=sext(S), reg_wr=0.
  - reg_wr is forced to 0 when rd=0.
- Illegal encodings:
  - Covers any other opcode, a bad ALUR func7, and a bad func7 for shift-immediates.
  - Result: illegal=1, reg_wr=0, mem_rd=0, mem_wr=0, is_branch=0, is_jump=0; the op is still queued in order.
- Immediates are sign-extended to DATA_W.

Decomposition:
- defines.vh gets: OPCODE_LUI/AUIPC/JAL/JALR/LOAD/STORE, ALU_SRC_ZERO, ALU_SRC_FOUR, ALU_SRC_W=2, and the micro-op field width constants.
- Sub-module id_decoder: purely combinational inst → micro-op fields.
- stage_id_q holds the queue, pointers, count and handshakes.

Test Plan:
- ADDI x1,x0,5 (0x00500093), queue empty, out_ready=1 → next cycle: out_valid=1, rd=1, reg_wr=1, alu_op=0000, src R/IMM, imm=5.
- SUB x3,x1,x2 (0x402081B3) → alu_op=1000, src R/R, r1=1, r2=2, rd=3. ADDI x0,x0,0 → reg_wr=0.
- BEQ x0,x0,-8 (0xFE000CE3) at pc=0x100 → is_branch=1, branch_type=000, imm=0xFFFFFFF8, src PC/IMM, out_pc=0x100, reg_wr=0.
- LW x5,8(x2) (0x00812283) → mem_rd=1, mem_size=010, imm=8. JAL x1,16 (0x010000EF) → is_jump=1, src PC/FOUR, imm=16, reg_wr=1.
- Backpressure: out_ready=0, three back-to-back in_valid → in_ready=0 after 2 accepts; release out_ready → ops exit in order, third accepted after first pop.
- Queue holding 2 ops, flush=1 with in_valid=1 → next cycle out_valid=0, count=0, input dropped. rst asserted mid-stream → immediate out_valid=0, in_ready=1.
